gen_clk_en_gen: RTL and testbench
=================================

GEN_CLK_EN_GEN -- requirements
Module: gen_clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent clock-enable channels.
REQ-002 SHALL have parameter ACC_W, default 32, phase-accumulator and increment width.
REQ-003 SHALL have parameter TMO, default 1024, switch-timeout limit in local_clk cycles.
REQ-004 SHALL have parameter CNT_W, default 16, selected-channel tick-counter width.
REQ-005 SHALL have port local_clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cfg_wr  in  1  increment write strobe.
REQ-008 SHALL have port cfg_ch  in  $clog2(NUM_CH)  channel addressed by cfg_wr.
REQ-009 SHALL have port cfg_inc  in  ACC_W  phase increment to store.
REQ-010 SHALL have port ch_en  in  NUM_CH  per-channel run enable.
REQ-011 SHALL have port sel_valid / sel_ready  in / out  1  channel-switch request handshake.
REQ-012 SHALL have port sel_req  in  $clog2(NUM_CH)  requested output channel.
REQ-013 SHALL have port tick / lvl  out  NUM_CH  per-channel one-cycle enable pulse / toggle level.
REQ-014 SHALL have port sel_tick  out  1  gated tick of the selected channel.
REQ-015 SHALL have port sel_ch  out  $clog2(NUM_CH)  currently selected channel.
REQ-016 SHALL have port sel_err  out  1  one-cycle switch-timeout pulse.
REQ-017 SHALL have port tick_cnt  out  CNT_W  ticks seen on sel_ch since last switch.

Function
REQ-018 SHALL, each cycle with ch_en[i]=1, set acc[i] <= acc[i]+inc[i] modulo 2^ACC_W; tick[i] SHALL be the registered carry-out (1-cycle latency).
REQ-019 SHALL make cfg_wr take effect on the next accumulation; acc[i] not cleared; cfg_ch >= NUM_CH ignored.
REQ-020 SHALL, with inc[i]=0, never assert tick[i].
REQ-021 SHALL, while ch_en[i]=0, hold acc[i], tick[i], lvl[i] at 0.
REQ-022 SHALL toggle lvl[i] in the cycle after each tick[i] (square wave at half tick rate).
REQ-023 SHALL run switch FSM IDLE, DRAIN, ARM; sel_ready=1 only in IDLE.
REQ-024 IDLE: sel_valid&sel_ready with sel_req==sel_ch SHALL be accepted with no state change; sel_req >= NUM_CH SHALL be accepted, ignored; otherwise latch target, go DRAIN.
REQ-025 DRAIN: SHALL wait for tick[sel_ch] (immediately exit if ch_en[sel_ch]=0), then force sel_tick=0 and go ARM.
REQ-026 ARM: on first tick[target], sel_ch <= target, tick_cnt <= 0, go IDLE; that tick SHALL NOT appear on sel_tick; subsequent ticks pass.
REQ-027 SHALL, in IDLE, drive sel_tick = tick[sel_ch]; sel_tick SHALL be 0 in DRAIN exit cycle and all of ARM.
REQ-028 SHALL count cycles spent in DRAIN+ARM; reaching TMO SHALL pulse sel_err, keep sel_ch, return IDLE.
REQ-029 SHALL increment tick_cnt on each sel_tick, wrapping 2^CNT_W-1 -> 0.
REQ-030 SHALL let cfg_wr and ch_en changes apply at any FSM state without aborting the switch.

Reset
REQ-031 SHALL, on rst=0, asynchronously clear all acc, inc, tick, lvl, sel_tick, sel_err, tick_cnt, timeout counter; sel_ch=0; FSM=IDLE.
REQ-032 SHALL drive sel_ready=1 from the first cycle after rst deasserts; reset mid-switch SHALL abandon the switch.

Structure
REQ-033 SHALL place the FSM state enum and default parameter constants in shared package clk_gen_pkg.
REQ-034 SHALL use one sub-module, phase_acc_ch (accumulator, tick, lvl), instantiated NUM_CH times.

Verification (bench ACC_W=8, NUM_CH=4, TMO=32)
REQ-035 inc[0]=64, ch_en=0001 -> tick[0] every 4 cycles, lvl[0] period 8, first tick 4 cycles after enable.
REQ-036 inc[1]=255 -> 255 ticks per 256 cycles; inc[2]=0 -> no ticks for 1000 cycles.
REQ-037 sel_ch=0 (inc 64), request 1 (inc 128) -> sel_ready low until first tick[1] after a tick[0]; no sel_tick in ARM; tick_cnt restarts at 0.
REQ-038 request channel 3 with ch_en[3]=0 -> sel_err pulse after 32 cycles, sel_ch stays 0, sel_ready returns 1.
REQ-039 assert rst mid-ARM -> all outputs 0, sel_ch=0, sel_ready=1 next cycle after release.
REQ-040 CNT_W=4, 17 sel_ticks -> tick_cnt wraps to 1; cfg_wr during DRAIN -> switch completes normally.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator slice.
// Holds the default parameter values used by gen_clk_en_gen and
// phase_acc_ch, plus the channel-switch FSM state encoding.
package clk_gen_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_TMO    = 1024;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_DRAIN = 2'd1,
    SW_ARM   = 2'd2
  } sw_state_e;

endpackage

// File: rtl/phase_acc_ch.sv
// One phase-accumulator clock-enable channel.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   en_i    - run enable; while low, acc/tick/lvl are held at 0
//   inc_i   - phase increment added every enabled cycle
//   tick_o  - registered carry-out of the accumulator (one-cycle pulse)
//   lvl_o   - toggles in the cycle after each tick (half-rate square wave)
module phase_acc_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             tick_o,
  output logic             lvl_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic             lvl_q, lvl_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_i};
    acc_d  = '0;
    tick_d = 1'b0;
    lvl_d  = 1'b0;
    if (en_i) begin
      acc_d  = sum[ACC_W-1:0];
      tick_d = sum[ACC_W];
      lvl_d  = lvl_q ^ tick_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
      lvl_q  <= lvl_d;
    end
  end

  assign tick_o = tick_q;
  assign lvl_o  = lvl_q;

endmodule

// File: rtl/gen_clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a glitch-free
// output-channel switch.
// Ports:
//   local_clk           - sole clock, rising edge
//   rst                 - asynchronous active-low reset
//   cfg_wr/cfg_ch/cfg_inc - write a channel's phase increment
//   ch_en               - per-channel run enable
//   sel_valid/sel_ready - channel-switch request handshake (ready only in IDLE)
//   sel_req             - requested output channel
//   tick/lvl            - per-channel enable pulse / toggle level
//   sel_tick            - tick of the selected channel, gated during a switch
//   sel_ch              - currently selected channel
//   sel_err             - one-cycle pulse when a switch times out
//   tick_cnt            - sel_tick count since the last completed switch
module gen_clk_en_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned TMO    = DEF_TMO,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                      local_clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]          cfg_inc,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic [$clog2(NUM_CH)-1:0] sel_req,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         lvl,
  output logic                      sel_tick,
  output logic [$clog2(NUM_CH)-1:0] sel_ch,
  output logic                      sel_err,
  output logic [CNT_W-1:0]          tick_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);
  localparam int unsigned TMO_W = $clog2(TMO + 1);

  logic [ACC_W-1:0] inc_q [NUM_CH];

  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) inc_q[i] <= '0;
    end else if (cfg_wr && (32'(cfg_ch) < NUM_CH)) begin
      inc_q[cfg_ch] <= cfg_inc;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    phase_acc_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk_i (local_clk),
      .rst_ni(rst),
      .en_i  (ch_en[g]),
      .inc_i (inc_q[g]),
      .tick_o(tick[g]),
      .lvl_o (lvl[g])
    );
  end

  sw_state_e        state_q, state_d;
  logic [SEL_W-1:0] sel_ch_q, sel_ch_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_err_q, sel_err_d;
  logic             timeout;

  // tmo_q counts cycles spent in DRAIN+ARM; it is cleared on accept so the
  // TMO-th cycle of a switch is the one that aborts it.
  always_comb begin
    state_d   = state_q;
    sel_ch_d  = sel_ch_q;
    target_d  = target_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    sel_err_d = 1'b0;
    sel_tick  = 1'b0;
    timeout   = (tmo_q == TMO_W'(TMO - 1));
    unique case (state_q)
      SW_IDLE: begin
        sel_tick = tick[sel_ch_q];
        if (sel_tick) cnt_d = cnt_q + CNT_W'(1);
        if (sel_valid && (32'(sel_req) < NUM_CH) && (sel_req != sel_ch_q)) begin
          target_d = sel_req;
          tmo_d    = '0;
          state_d  = SW_DRAIN;
        end
      end
      SW_DRAIN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout) begin
          sel_err_d = 1'b1;
          state_d   = SW_IDLE;
        end else if (tick[sel_ch_q] || !ch_en[sel_ch_q]) begin
          state_d = SW_ARM;
        end
      end
      SW_ARM: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout) begin
          sel_err_d = 1'b1;
          state_d   = SW_IDLE;
        end else if (tick[target_q]) begin
          // The target's first tick only aligns the switch; it is swallowed.
          sel_ch_d = target_q;
          cnt_d    = '0;
          state_d  = SW_IDLE;
        end
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SW_IDLE;
      sel_ch_q  <= '0;
      target_q  <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_ch_q  <= sel_ch_d;
      target_q  <= target_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_ready = (state_q == SW_IDLE);
  assign sel_ch    = sel_ch_q;
  assign sel_err   = sel_err_q;
  assign tick_cnt  = cnt_q;

endmodule

// File: tb/tb_gen_clk_en_gen.sv
module tb_gen_clk_en_gen;

  logic       local_clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic [3:0] ch_en = '0;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic [1:0] sel_req = '0;
  logic [3:0] tick, lvl;
  logic       sel_tick;
  logic [1:0] sel_ch;
  logic       sel_err;
  logic [3:0] tick_cnt;

  gen_clk_en_gen #(
    .NUM_CH(4),
    .ACC_W (8),
    .TMO   (32),
    .CNT_W (4)
  ) dut (
    .local_clk(local_clk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .ch_en    (ch_en),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .sel_req  (sel_req),
    .tick     (tick),
    .lvl      (lvl),
    .sel_tick (sel_tick),
    .sel_ch   (sel_ch),
    .sel_err  (sel_err),
    .tick_cnt (tick_cnt)
  );

  initial forever #5 local_clk = ~local_clk;

  int cyc = 0;
  always @(posedge local_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard queues: expected cycle (and value) of each DUT event.
  int exp_tick_q[$];
  int exp_lvl_q[$];
  int exp_st_cyc[$];
  int exp_st_cnt[$];
  int exp_rdy_cyc[$];
  int exp_rdy_val[$];
  int exp_ch_cyc[$];
  int exp_ch_val[$];
  int exp_err_cyc[$];

  logic [3:0] watch_tick = '0;
  logic       watch_lvl = 1'b0;
  logic       watch_sel = 1'b0;
  int         seen [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge local_clk);
    #1;
  endtask

  task automatic drained(input string phase);
    chk({phase, "_tick_left"}, exp_tick_q.size(), 0);
    chk({phase, "_lvl_left"}, exp_lvl_q.size(), 0);
    chk({phase, "_seltick_left"}, exp_st_cyc.size(), 0);
    chk({phase, "_ready_left"}, exp_rdy_cyc.size(), 0);
    chk({phase, "_selch_left"}, exp_ch_cyc.size(), 0);
    chk({phase, "_err_left"}, exp_err_cyc.size(), 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  logic prev_lvl0 = 1'b0;
  logic prev_rdy = 1'b0;
  logic [1:0] prev_ch = '0;
  initial begin
    forever begin
      @(negedge local_clk);
      for (int i = 0; i < 4; i++) begin
        if (tick[i] === 1'b1) begin
          seen[i] = seen[i] + 1;
          if (watch_tick[i]) begin
            if (exp_tick_q.size() == 0) chk($sformatf("tick%0d_unexpected", i), cyc, -1);
            else chk($sformatf("tick%0d_cycle", i), cyc, exp_tick_q.pop_front());
          end
        end
      end
      if (watch_lvl && lvl[0] && !prev_lvl0) begin
        if (exp_lvl_q.size() == 0) chk("lvl0_rise_unexpected", cyc, -1);
        else chk("lvl0_rise_cycle", cyc, exp_lvl_q.pop_front());
      end
      if (watch_sel) begin
        if (sel_tick === 1'b1) begin
          if (exp_st_cyc.size() == 0) chk("sel_tick_unexpected", cyc, -1);
          else begin
            chk("sel_tick_cycle", cyc, exp_st_cyc.pop_front());
            chk("tick_cnt_at_sel_tick", int'(tick_cnt), exp_st_cnt.pop_front());
          end
        end
        if (sel_ready !== prev_rdy) begin
          if (exp_rdy_cyc.size() == 0) chk("sel_ready_change_unexpected", cyc, -1);
          else begin
            chk("sel_ready_change_cycle", cyc, exp_rdy_cyc.pop_front());
            chk("sel_ready_value", int'(sel_ready), exp_rdy_val.pop_front());
          end
        end
        if (sel_ch !== prev_ch) begin
          if (exp_ch_cyc.size() == 0) chk("sel_ch_change_unexpected", cyc, -1);
          else begin
            chk("sel_ch_change_cycle", cyc, exp_ch_cyc.pop_front());
            chk("sel_ch_value", int'(sel_ch), exp_ch_val.pop_front());
          end
        end
        if (sel_err === 1'b1) begin
          if (exp_err_cyc.size() == 0) chk("sel_err_unexpected", cyc, -1);
          else chk("sel_err_cycle", cyc, exp_err_cyc.pop_front());
        end
      end
      prev_lvl0 = lvl[0];
      prev_rdy  = sel_ready;
      prev_ch   = sel_ch;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int base2;

    // Reset state
    repeat (3) step();
    chk("rst_tick", int'(tick), 0);
    chk("rst_lvl", int'(lvl), 0);
    chk("rst_sel_ch", int'(sel_ch), 0);
    chk("rst_tick_cnt", int'(tick_cnt), 0);
    chk("rst_sel_err", int'(sel_err), 0);
    rst = 1'b1;
    step();
    chk("post_rst_sel_ready", int'(sel_ready), 1);

    // Increments: ch0=64, ch1=255, ch2=0
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64;
    step(); cfg_ch = 2'd1; cfg_inc = 8'd255;
    step(); cfg_ch = 2'd2; cfg_inc = 8'd0;
    step(); cfg_wr = 1'b0;
    step();

    // Phase 1: ch0 inc 64 -> tick every 4, lvl period 8, tick_cnt wraps at 16
    e = cyc;
    for (int k = 1; k <= 20; k++) begin
      exp_tick_q.push_back(e + 4 * k);
      exp_st_cyc.push_back(e + 4 * k);
      exp_st_cnt.push_back((k - 1) % 16);
    end
    for (int j = 0; j < 10; j++) exp_lvl_q.push_back(e + 5 + 8 * j);
    watch_tick = 4'b0001; watch_lvl = 1'b1; watch_sel = 1'b1;
    ch_en = 4'b0001;
    while (cyc < e + 82) step();
    watch_tick = '0; watch_lvl = 1'b0; watch_sel = 1'b0;
    ch_en = 4'b0000;
    step(); step();
    chk("dis_tick0", int'(tick[0]), 0);
    chk("dis_lvl0", int'(lvl[0]), 0);
    chk("p1_tick_cnt_wrapped", int'(tick_cnt), 4);
    drained("p1");

    // Phase 2: ch1 inc 255 (tick on all but 1 of 256 steps), ch2 inc 0
    e = cyc;
    for (int n = 2; n <= 256; n++) exp_tick_q.push_back(e + n);
    exp_tick_q.push_back(e + 258);
    base2 = seen[2];
    watch_tick = 4'b0010;
    ch_en = 4'b0110;
    while (cyc < e + 259) step();
    watch_tick = '0;
    drained("p2");
    while (cyc < e + 1000) step();
    chk("ch2_inc0_ticks", seen[2] - base2, 0);
    ch_en = 4'b0000;
    step(); step();

    // Phase 4: same-channel request is a no-op; request to disabled ch3 times out
    watch_sel = 1'b1;
    sel_valid = 1'b1; sel_req = 2'd0;
    step(); sel_valid = 1'b0;
    step(); step();
    chk("same_ch_ready", int'(sel_ready), 1);
    e = cyc;
    exp_rdy_cyc.push_back(e + 2);  exp_rdy_val.push_back(0);
    exp_rdy_cyc.push_back(e + 34); exp_rdy_val.push_back(1);
    exp_err_cyc.push_back(e + 34);
    exp_st_cyc.push_back(e + 36); exp_st_cnt.push_back(4);
    exp_st_cyc.push_back(e + 40); exp_st_cnt.push_back(5);
    ch_en = 4'b0001;
    step(); sel_valid = 1'b1; sel_req = 2'd3;
    step(); sel_valid = 1'b0;
    while (cyc < e + 41) step();
    ch_en = 4'b0000; watch_sel = 1'b0;
    chk("tmo_sel_ch_kept", int'(sel_ch), 0);
    drained("p4");

    // Phase 3: switch 0 (inc 64) -> 1 (inc 128), cfg write during DRAIN
    step(); cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd128;
    step(); cfg_wr = 1'b0;
    step();
    e = cyc;
    exp_st_cyc.push_back(e + 4);  exp_st_cnt.push_back(6);
    exp_st_cyc.push_back(e + 12); exp_st_cnt.push_back(0);
    exp_st_cyc.push_back(e + 14); exp_st_cnt.push_back(1);
    exp_st_cyc.push_back(e + 16); exp_st_cnt.push_back(2);
    exp_rdy_cyc.push_back(e + 6);  exp_rdy_val.push_back(0);
    exp_rdy_cyc.push_back(e + 11); exp_rdy_val.push_back(1);
    exp_ch_cyc.push_back(e + 11);  exp_ch_val.push_back(1);
    watch_sel = 1'b1;
    ch_en = 4'b0011;
    while (cyc < e + 5) step();
    sel_valid = 1'b1; sel_req = 2'd1;
    step(); sel_valid = 1'b0;
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd128;
    step(); cfg_wr = 1'b0;
    while (cyc < e + 17) step();
    ch_en = 4'b0000; watch_sel = 1'b0;
    step();
    chk("p3_tick_cnt", int'(tick_cnt), 3);
    chk("p3_sel_ch", int'(sel_ch), 1);
    drained("p3");

    // Phase 5: reset asserted while ARM waits on disabled ch2
    e = cyc;
    ch_en = 4'b0011;
    sel_valid = 1'b1; sel_req = 2'd2;
    step(); sel_valid = 1'b0;
    while (cyc < e + 6) step();
    chk("arm_sel_ready", int'(sel_ready), 0);
    rst = 1'b0;
    #1;
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_lvl", int'(lvl), 0);
    chk("midrst_sel_tick", int'(sel_tick), 0);
    chk("midrst_sel_err", int'(sel_err), 0);
    chk("midrst_sel_ch", int'(sel_ch), 0);
    chk("midrst_tick_cnt", int'(tick_cnt), 0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rel_sel_ready", int'(sel_ready), 1);
    chk("rel_sel_ch", int'(sel_ch), 0);
    repeat (6) step();
    chk("rel_inc_cleared_tick", int'(tick), 0);
    ch_en = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
